// File: rtl/sat_add_rr_arb.sv
// Round-robin arbiter that shares one signed saturating adder among NREQ requesters,
// with a single registered output slot and a saturating count of clipped results.
module sat_add_rr_arb #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic              out_ovf,
  output logic              out_uvf,
  output logic [IDW-1:0]    out_id,
  input  logic              cnt_clr,
  output logic [7:0]        sat_count
);

  logic              r_out_valid;
  logic [W-1:0]      r_sum;
  logic              r_ovf;
  logic              r_uvf;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    r_ptr;
  logic [7:0]        r_cnt;

  logic              w_any;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW-1:0]    w_ptr_nxt;
  int unsigned       w_idx;
  logic              w_can_accept;
  logic              w_accept;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;
  logic [W:0]        w_s;
  logic              w_ovf;
  logic              w_uvf;
  logic [W-1:0]      w_sum;

  // Scan from the pointer upward with wrap; the first valid requester wins.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && req_valid[w_idx[IDW-1:0]]) begin
        w_any    = 1'b1;
        w_gnt_id = w_idx[IDW-1:0];
      end
    end
  end

  assign w_ptr_nxt    = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_accept     = w_can_accept && w_any;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_id] = 1'b1;
  end

  assign w_a = req_a[w_gnt_id*W +: W];
  assign w_b = req_b[w_gnt_id*W +: W];
  assign w_s = {w_a[W-1], w_a} + {w_b[W-1], w_b};

  // Sign bit and the bit below disagree only when the true sum left the W-bit range.
  assign w_ovf = ~w_s[W] &  w_s[W-1];
  assign w_uvf =  w_s[W] & ~w_s[W-1];
  assign w_sum = w_ovf ? {1'b0, {(W-1){1'b1}}} :
                 w_uvf ? {1'b1, {(W-1){1'b0}}} : w_s[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_uvf       <= 1'b0;
      r_id        <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_ovf       <= w_ovf;
      r_uvf       <= w_uvf;
      r_id        <= w_gnt_id;
      r_ptr       <= w_ptr_nxt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_accept && (w_ovf || w_uvf) && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_ovf   = r_ovf;
  assign out_uvf   = r_uvf;
  assign out_id    = r_id;
  assign sat_count = r_cnt;

endmodule
